// File: rtl/vga_pattern_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pattern_ctrl_if
//  Description : Control and timing bundle between the VGA pattern sequencer
//                and its pattern-select / colour-generator consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_pattern_ctrl_if;
    logic       pause;
    logic       next_req;
    logic [9:0] horizontal_num;
    logic [9:0] vertical_num;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic [1:0] pattern_sel;

    modport master (
        output pause, next_req,
        input  horizontal_num, vertical_num, hsync, vsync, video_on,
               frame_start, pattern_sel
    );

    modport slave (
        input  pause, next_req,
        output horizontal_num, vertical_num, hsync, vsync, video_on,
               frame_start, pattern_sel
    );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pattern_ctrl
//  Description : 640x480 VGA timing generator plus four-pattern sequencer that
//                only switches patterns on frame boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_ctrl #(
    parameter int HVID               = 640,
    parameter int HFP                = 16,
    parameter int HSYNC              = 96,
    parameter int HBP                = 48,
    parameter int VVID               = 480,
    parameter int VFP                = 10,
    parameter int VSYNC              = 2,
    parameter int VBP                = 33,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  wire logic          clk_25,
    input  wire logic          rst,
    vga_pattern_ctrl_if.slave  bus
);

    localparam int c_HTOT = HVID + HFP + HSYNC + HBP;
    localparam int c_VTOT = VVID + VFP + VSYNC + VBP;
    localparam int c_FCW  = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

    localparam logic [9:0]       c_H_LAST   = 10'(c_HTOT - 1);
    localparam logic [9:0]       c_V_LAST   = 10'(c_VTOT - 1);
    localparam logic [9:0]       c_H_VIS    = 10'(HVID);
    localparam logic [9:0]       c_V_VIS    = 10'(VVID);
    localparam logic [9:0]       c_HS_START = 10'(HVID + HFP);
    localparam logic [9:0]       c_HS_END   = 10'(HVID + HFP + HSYNC);
    localparam logic [9:0]       c_VS_START = 10'(VVID + VFP);
    localparam logic [9:0]       c_VS_END   = 10'(VVID + VFP + VSYNC);
    localparam logic [c_FCW-1:0] c_FC_LAST  = c_FCW'(FRAMES_PER_PATTERN - 1);

    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_frame_start;
    logic [1:0]       r_pattern;
    logic [c_FCW-1:0] r_frame_cnt;
    logic             r_pending;

    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;
    logic             w_h_wrap;
    logic             w_fb;
    logic             w_advance;

    always_comb begin
        w_h_wrap  = (r_h == c_H_LAST);
        w_fb      = w_h_wrap && (r_v == c_V_LAST);
        w_h_next  = w_h_wrap ? 10'd0 : r_h + 10'd1;
        w_v_next  = r_v;
        if (w_h_wrap) begin
            w_v_next = (r_v == c_V_LAST) ? 10'd0 : r_v + 10'd1;
        end
        // A request landing on the boundary edge itself still counts for it.
        w_advance = w_fb && (r_pending || bus.next_req ||
                             (!bus.pause && (r_frame_cnt == c_FC_LAST)));
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b1;
            r_frame_start <= 1'b0;
            r_pattern     <= 2'd0;
            r_frame_cnt   <= '0;
            r_pending     <= 1'b0;
        end else begin
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            // Decodes use next-state counters so they line up with r_h/r_v.
            r_hsync       <= !((w_h_next >= c_HS_START) && (w_h_next < c_HS_END));
            r_vsync       <= !((w_v_next >= c_VS_START) && (w_v_next < c_VS_END));
            r_video_on    <= (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
            r_frame_start <= w_fb;
            if (w_fb) begin
                r_pending <= 1'b0;
                if (w_advance) begin
                    r_pattern   <= r_pattern + 2'd1;
                    r_frame_cnt <= '0;
                end else if (!bus.pause) begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end else if (bus.next_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.horizontal_num = r_h;
    assign bus.vertical_num   = r_v;
    assign bus.hsync          = r_hsync;
    assign bus.vsync          = r_vsync;
    assign bus.video_on       = r_video_on;
    assign bus.frame_start    = r_frame_start;
    assign bus.pattern_sel    = r_pattern;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pattern_ctrl
//  Description : Self-checking bench for vga_pattern_ctrl on a shrunken raster,
//                compared against a frame-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_ctrl;

    localparam int HVID  = 16, HFP = 2, HSYNC = 3, HBP = 3;
    localparam int VVID  = 8,  VFP = 1, VSYNC = 2, VBP = 2;
    localparam int FPP   = 2;
    localparam int HTOT  = HVID + HFP + HSYNC + HBP;
    localparam int VTOT  = VVID + VFP + VSYNC + VBP;
    localparam int FRAME = HTOT * VTOT;

    logic clk_25 = 1'b0;
    logic rst    = 1'b1;

    vga_pattern_ctrl_if bus ();

    vga_pattern_ctrl #(
        .HVID(HVID), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
        .VVID(VVID), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
        .FRAMES_PER_PATTERN(FPP)
    ) dut (
        .clk_25 (clk_25),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #20 clk_25 = ~clk_25;

    int errors = 0;
    int checks = 0;

    // Model: absolute cycle index since reset release plus frame-level pattern state.
    int m_t;
    int m_pat;
    int m_fcnt;
    bit m_req;
    bit m_fs;

    function automatic logic [23:0] exp_vec();
        int eh, ev;
        logic ehs, evs, evon;
        eh   = m_t % HTOT;
        ev   = (m_t / HTOT) % VTOT;
        ehs  = !((eh >= HVID + HFP) && (eh < HVID + HFP + HSYNC));
        evs  = !((ev >= VVID + VFP) && (ev < VVID + VFP + VSYNC));
        evon = (eh < HVID) && (ev < VVID);
        return {10'(eh), 10'(ev), ehs, evs, evon, m_fs};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {bus.horizontal_num, bus.vertical_num, bus.hsync, bus.vsync,
                bus.video_on, bus.frame_start};
    endfunction

    task automatic model_reset();
        m_t = 0; m_pat = 0; m_fcnt = 0; m_req = 0; m_fs = 0;
    endtask

    // Advance model and DUT one clock; next_req is a one-cycle pulse.
    task automatic tick();
        bit fb;
        fb = ((m_t % FRAME) == FRAME - 1);
        if (fb) begin
            if (m_req || bus.next_req || (!bus.pause && m_fcnt == FPP - 1)) begin
                m_pat  = (m_pat + 1) % 4;
                m_fcnt = 0;
            end else if (!bus.pause) begin
                m_fcnt++;
            end
            m_req = 0;
        end else if (bus.next_req) begin
            m_req = 1;
        end
        m_fs = fb;
        m_t++;
        @(posedge clk_25);
        #1;
        bus.next_req = 1'b0;
    endtask

    task automatic goto_pos(input int p);
        while ((m_t % FRAME) != p) tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 150; i++) begin
            bus.next_req = ($urandom_range(0, 9) == 0);
            tick();
        end
        bus.next_req = 1'b1;
        tick();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk_25);
            #1;
        end
        rst = 1'b0;
        model_reset();
        checks++;
        if (dut_vec() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", dut_vec(),
                     {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        end
        checks++;
        if (bus.pattern_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_pattern got=%0d exp=0", bus.pattern_sel);
        end
        tick();
        checks++;
        if (bus.horizontal_num !== 10'd1 || bus.vertical_num !== 10'd0) begin
            errors++;
            $display("FAIL reset_first_step got=(%0d,%0d) exp=(1,0)",
                     bus.horizontal_num, bus.vertical_num);
        end
        goto_pos(0);
        checks++;
        if (bus.pattern_sel !== 2'd0 || bus.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_stale_req got pat=%0d fs=%b exp pat=0 fs=1",
                     bus.pattern_sel, bus.frame_start);
        end
    endtask

    task automatic test_line_frame_timing();
        int hs_low, vs_low, last_fs;
        hs_low  = 0;
        vs_low  = 0;
        last_fs = m_t;
        for (int i = 0; i < 2 * FRAME; i++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL timing t=%0d got=%h exp=%h", m_t, dut_vec(), exp_vec());
            end
            if (bus.hsync === 1'b0) hs_low++;
            if (bus.vsync === 1'b0) vs_low++;
            if ((m_t % HTOT) == HTOT - 1) begin
                checks++;
                if (hs_low != HSYNC) begin
                    errors++;
                    $display("FAIL hsync_width got=%0d exp=%0d", hs_low, HSYNC);
                end
                hs_low = 0;
            end
            if ((m_t % FRAME) == FRAME - 1) begin
                checks++;
                if (vs_low != VSYNC * HTOT) begin
                    errors++;
                    $display("FAIL vsync_width got=%0d exp=%0d", vs_low, VSYNC * HTOT);
                end
                vs_low = 0;
            end
            if (bus.frame_start === 1'b1 && i > 0) begin
                checks++;
                if (m_t - last_fs != FRAME) begin
                    errors++;
                    $display("FAIL frame_start_period got=%0d exp=%0d", m_t - last_fs, FRAME);
                end
                last_fs = m_t;
            end
            tick();
        end
    endtask

    task automatic test_auto_advance();
        logic [1:0] prev;
        bus.pause = 1'b0;
        goto_pos(0);
        prev = bus.pattern_sel;
        for (int i = 0; i < 9 * FRAME; i++) begin
            tick();
            checks++;
            if (bus.pattern_sel !== 2'(m_pat)) begin
                errors++;
                $display("FAIL auto_pattern t=%0d got=%0d exp=%0d", m_t, bus.pattern_sel, m_pat);
            end
            if (bus.pattern_sel !== prev) begin
                checks++;
                if (bus.horizontal_num !== 10'd0 || bus.vertical_num !== 10'd0) begin
                    errors++;
                    $display("FAIL auto_change_midframe got=(%0d,%0d) exp=(0,0)",
                             bus.horizontal_num, bus.vertical_num);
                end
            end
            prev = bus.pattern_sel;
        end
    endtask

    task automatic test_next_req();
        int p0;
        bus.pause = 1'b0;
        goto_pos(0);
        while (m_fcnt != FPP - 1) begin
            tick();
            goto_pos(0);
        end
        p0 = int'(bus.pattern_sel);
        goto_pos(3 * HTOT + 5);
        bus.next_req = 1'b1;
        tick();
        goto_pos(3 * HTOT + 10);
        bus.next_req = 1'b1;
        tick();
        goto_pos(FRAME - 1);
        checks++;
        if (bus.pattern_sel !== 2'(p0)) begin
            errors++;
            $display("FAIL req_early_change got=%0d exp=%0d", bus.pattern_sel, p0);
        end
        bus.next_req = 1'b1;
        tick();
        checks++;
        if (bus.pattern_sel !== 2'((p0 + 1) % 4)) begin
            errors++;
            $display("FAIL req_single_advance got=%0d exp=%0d", bus.pattern_sel, (p0 + 1) % 4);
        end
        // Request exactly on the boundary edge, with no auto-advance due.
        goto_pos(FRAME - 1);
        bus.next_req = 1'b1;
        tick();
        checks++;
        if (bus.pattern_sel !== 2'((p0 + 2) % 4)) begin
            errors++;
            $display("FAIL req_on_fb got=%0d exp=%0d", bus.pattern_sel, (p0 + 2) % 4);
        end
        goto_pos(FRAME - 1);
        tick();
        checks++;
        if (bus.pattern_sel !== 2'((p0 + 2) % 4)) begin
            errors++;
            $display("FAIL req_cnt_cleared got=%0d exp=%0d", bus.pattern_sel, (p0 + 2) % 4);
        end
        goto_pos(FRAME - 1);
        tick();
        checks++;
        if (bus.pattern_sel !== 2'((p0 + 3) % 4)) begin
            errors++;
            $display("FAIL req_auto_after got=%0d exp=%0d", bus.pattern_sel, (p0 + 3) % 4);
        end
    endtask

    task automatic test_pause();
        int p0, exp_p;
        goto_pos(0);
        p0 = int'(bus.pattern_sel);
        bus.pause = 1'b1;
        for (int f = 0; f < 7; f++) begin
            if (f == 5) bus.pause = 1'b0;
            exp_p = (f >= 3) ? (p0 + 1) % 4 : p0;
            for (int c = 0; c < FRAME; c++) begin
                if (f == 2 && c == 50) bus.next_req = 1'b1;
                if (c == 0 || c == FRAME - 1) begin
                    checks++;
                    if (bus.pattern_sel !== 2'(exp_p)) begin
                        errors++;
                        $display("FAIL pause_hold f=%0d c=%0d got=%0d exp=%0d",
                                 f, c, bus.pattern_sel, exp_p);
                    end
                end
                tick();
            end
        end
        checks++;
        if (bus.pattern_sel !== 2'((p0 + 2) % 4)) begin
            errors++;
            $display("FAIL pause_resume got=%0d exp=%0d", bus.pattern_sel, (p0 + 2) % 4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20 * FRAME; i++) begin
            bus.next_req = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 399) == 0) bus.pause = ~bus.pause;
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || bus.pattern_sel !== 2'(m_pat)) begin
                errors++;
                $display("FAIL random t=%0d got=%h/%0d exp=%h/%0d",
                         m_t, dut_vec(), bus.pattern_sel, exp_vec(), m_pat);
            end
        end
        bus.pause = 1'b0;
    endtask

    initial begin
        bus.pause    = 1'b0;
        bus.next_req = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk_25);
        #1;
        rst = 1'b0;
        model_reset();
        test_reset();
        test_line_frame_timing();
        test_auto_advance();
        test_next_req();
        test_pause();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
